// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit and sequencer for the E stage.
// Owns the architectural HI/LO registers. A MULT/DIV result is computed
// into a shadow pair when the operation is accepted and is only copied to
// HI/LO on the final busy edge, so the pipeline never sees a partial result.
// MTHI/MTLO write HI/LO directly and never make the unit busy.
//
// Handshake: start is a one-cycle valid with no ready. The pipeline keeps
// MD instructions in D via stall_md while busy is high, so start never
// arrives while busy; if it does, it is ignored.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_md_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic        commit;

  logic [31:0] shadow_hi, shadow_lo;
  logic        div_zero;

  logic        accept;
  logic        is_signed;
  logic [63:0] product;
  logic [31:0] quotient, remainder;

  assign accept    = start && (state == IDLE);
  assign is_signed = ~md_op[0];
  assign busy      = (state != IDLE);
  assign stall_md  = is_md_d & (busy | start);

  // Arithmetic on the E-stage operands; only captured when an op is accepted.
  always_comb begin
    logic [63:0] a_ext, b_ext;
    logic [31:0] abs_a, abs_b, uq, ur;
    a_ext = is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    b_ext = is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    product = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. 0x80000000 / -1 falls
    // out as 0x80000000 rem 0 without a special case.
    abs_a = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
    abs_b = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
    if (abs_b == 32'd0) begin
      abs_b = 32'd1;
    end
    uq = abs_a / abs_b;
    ur = abs_a % abs_b;
    quotient  = (is_signed && (op_a[31] ^ op_b[31])) ? (32'd0 - uq) : uq;
    remainder = (is_signed && op_a[31]) ? (32'd0 - ur) : ur;
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Next-state: load the latency counter on accept, commit on 1 -> 0.
  always_comb begin
    state_n = state;
    count_n = count;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (md_op == OP_MULT || md_op == OP_MULTU) begin
            state_n = MUL;
            count_n = 4'(MUL_CYCLES);
          end else if (md_op == OP_DIV || md_op == OP_DIVU) begin
            state_n = DIV;
            count_n = 4'(DIV_CYCLES);
          end
        end
      end
      MUL, DIV: begin
        if (count <= 4'd1) begin
          state_n = IDLE;
          count_n = 4'd0;
          commit  = 1'b1;
        end else begin
          count_n = count - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 4'd0;
      end
    endcase
  end

  // HI/LO and shadow result: capture on accept, publish on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          shadow_hi <= product[63:32];
          shadow_lo <= product[31:0];
          div_zero  <= 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          shadow_hi <= remainder;
          shadow_lo <= quotient;
          div_zero  <= (op_b == 32'd0);
        end
        OP_MTHI: hi <= op_a;
        OP_MTLO: lo <= op_a;
        default: ;
      endcase
    end else if (commit && !div_zero) begin
      hi <= shadow_hi;
      lo <= shadow_lo;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with hand-computed HI/LO,
// busy duration, stall request and asynchronous reset behaviour.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_md_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .op_a     (op_a),
    .op_b     (op_b),
    .is_md_d  (is_md_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  // Clock: 10 time units, inputs driven and outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline never issues start while busy.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(start && busy)) else $error("start asserted while busy");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one MULT/DIV and follow it through its busy window.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input logic md_d,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    is_md_d = md_d;
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    #1;
    check({tag, " stall_start"}, 32'(stall_md), 32'(md_d));
    check({tag, " busy_start"}, 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hDEAD_BEEF;
    for (int i = 0; i < ncyc; i++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " hi_hold"}, hi, old_hi);
      check({tag, " lo_hold"}, lo, old_lo);
      check({tag, " stall_busy"}, 32'(stall_md), 32'(md_d));
      @(negedge clk);
    end
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    check({tag, " stall_done"}, 32'(stall_md), 32'd0);
    check({tag, " hi"}, hi, new_hi);
    check({tag, " lo"}, lo, new_lo);
    is_md_d = 1'b0;
  endtask

  // Issue a single-cycle op (MTHI/MTLO/reserved) and check the next cycle.
  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; op_a = 32'd0; op_b = 32'd0; is_md_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset stall", 32'(stall_md), 32'd0);
    reset = 1'b0;

    // MULT -3 * 5 = -15
    run_md("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 1'b0,
           32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFE);
    // DIV 7 / -2 = -3 rem 1
    run_md("div", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0,
           32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    // DIV most-negative / -1 wraps to itself with remainder 0
    run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0,
           32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
    // DIVU 100 / 7 = 14 rem 2
    run_md("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0,
           32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_000E);

    run_mt("mthi", 3'd4, 32'h1111_1111, 32'h1111_1111, 32'h0000_000E);
    run_mt("mtlo", 3'd5, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222);
    run_mt("rsvd", 3'd6, 32'h3333_3333, 32'h1111_1111, 32'h2222_2222);

    // DIVU by zero with a dependent MD instruction held in D: no commit.
    run_md("divz", 3'd3, 32'd5, 32'd0, 10, 1'b1,
           32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222);

    // Asynchronous reset during the third busy cycle of a MULT.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("arst busy1", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("arst busy3", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst hi", hi, 32'd0);
    check("arst lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst no_commit_hi", hi, 32'd0);
      check("arst no_commit_lo", lo, 32'd0);
    end
    run_mt("mtlo_post", 3'd5, 32'd5, 32'd0, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
